sad_thread_controller: RTL and testbench



---
 rtl/sad_thread_controller.sv | 169 ++++++++++++++++
 tb/tb_sad_thread_controller.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_thread_controller.sv
// sad_thread_controller: instruction-driven sequencer for the VBSME datapath.
// Decodes load-template and SAD-sweep opcodes. A load walks the template
// buffer through one BLK x BLK block; a sweep requests one SAD per candidate
// position in raster order and reports the minimum SAD and where it was found.
module sad_thread_controller #(
    parameter logic [5:0] OPC_SAD  = 6'b101000,
    parameter logic [5:0] OPC_LOAD = 6'b100000,
    parameter int         BLK      = 4,
    parameter int         WIN_W    = 16,
    parameter int         WIN_H    = 16,
    parameter int         SAD_W    = 16,
    localparam int        BW       = (BLK   > 1) ? $clog2(BLK)   : 1,
    localparam int        RW       = (WIN_H > 1) ? $clog2(WIN_H) : 1,
    localparam int        CW       = (WIN_W > 1) ? $clog2(WIN_W) : 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InstrValid,
    input  logic [31:0]      Instruction,
    output logic             InstrReady,
    output logic             LoadEn,
    output logic [BW-1:0]    LoadRow,
    output logic [BW-1:0]    LoadCol,
    output logic             SADsignal,
    output logic             SadStart,
    output logic [RW-1:0]    CandRow,
    output logic [CW-1:0]    CandCol,
    input  logic             SadValid,
    input  logic [SAD_W-1:0] SadValue,
    output logic             Done,
    output logic [SAD_W-1:0] BestSad,
    output logic [RW-1:0]    BestRow,
    output logic [CW-1:0]    BestCol,
    output logic             Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [BW-1:0] BLK_LAST = BW'(BLK - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(WIN_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIN_W - 1);

    state_t             state;
    logic               loaded;
    logic [SAD_W-1:0]   min_sad;
    logic [RW-1:0]      min_row;
    logic [CW-1:0]      min_col;

    logic [5:0]         opcode;
    logic               accept;
    logic               cand_last;
    logic               sad_better;

    // Operand bits of the instruction word carry nothing for this controller.
    logic               unused_operand;

    assign opcode         = Instruction[31:26];
    assign unused_operand = ^Instruction[25:0];
    assign accept         = InstrValid && InstrReady;
    assign cand_last      = (CandRow == ROW_LAST) && (CandCol == COL_LAST);
    // Strict compare: a tie keeps the earlier candidate in raster order.
    assign sad_better     = SadValue < min_sad;

    // State-decoded strobes; Done is high exactly for the single FINISH cycle.
    assign InstrReady = (state == S_IDLE);
    assign LoadEn     = (state == S_LOAD);
    assign SadStart   = (state == S_LAUNCH);
    assign SADsignal  = (state == S_LAUNCH) || (state == S_WAIT);
    assign Done       = (state == S_FINISH);

    // Sequencer: state, load/candidate counters, running minimum and results.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= S_IDLE;
            loaded  <= 1'b0;
            LoadRow <= '0;
            LoadCol <= '0;
            CandRow <= '0;
            CandCol <= '0;
            min_sad <= '1;
            min_row <= '0;
            min_col <= '0;
            BestSad <= '1;
            BestRow <= '0;
            BestCol <= '0;
            Error   <= 1'b0;
        end else begin
            Error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (opcode == OPC_LOAD) begin
                            LoadRow <= '0;
                            LoadCol <= '0;
                            state   <= S_LOAD;
                        end else if (opcode == OPC_SAD) begin
                            if (loaded) begin
                                CandRow <= '0;
                                CandCol <= '0;
                                min_sad <= '1;
                                min_row <= '0;
                                min_col <= '0;
                                state   <= S_LAUNCH;
                            end else begin
                                Error <= 1'b1;
                            end
                        end
                    end
                end

                S_LOAD: begin
                    if (LoadCol == BLK_LAST) begin
                        LoadCol <= '0;
                        if (LoadRow == BLK_LAST) begin
                            LoadRow <= '0;
                            loaded  <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            LoadRow <= LoadRow + 1'b1;
                        end
                    end else begin
                        LoadCol <= LoadCol + 1'b1;
                    end
                end

                S_LAUNCH: state <= S_WAIT;

                S_WAIT: begin
                    if (SadValid) begin
                        if (sad_better) begin
                            min_sad <= SadValue;
                            min_row <= CandRow;
                            min_col <= CandCol;
                        end
                        if (cand_last) begin
                            // Publish including this final result so Best is
                            // valid in the same cycle as Done.
                            BestSad <= sad_better ? SadValue : min_sad;
                            BestRow <= sad_better ? CandRow  : min_row;
                            BestCol <= sad_better ? CandCol  : min_col;
                            state   <= S_FINISH;
                        end else begin
                            if (CandCol == COL_LAST) begin
                                CandCol <= '0;
                                CandRow <= CandRow + 1'b1;
                            end else begin
                                CandCol <= CandCol + 1'b1;
                            end
                            state <= S_LAUNCH;
                        end
                    end
                end

                S_FINISH: state <= S_IDLE;

                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_thread_controller.sv
// tb_sad_thread_controller: scoreboard bench for sad_thread_controller with a
// 4x4 template and a 3x3 search window. Expected output events are queued as
// stimulus is issued; a monitor pops and compares each event the DUT presents.
module tb_sad_thread_controller;

    localparam int         BLK      = 4;
    localparam int         WIN_W    = 3;
    localparam int         WIN_H    = 3;
    localparam int         SAD_W    = 16;
    localparam logic [5:0] OPC_SAD  = 6'b101000;
    localparam logic [5:0] OPC_LOAD = 6'b100000;

    localparam int K_LOAD  = 0;
    localparam int K_START = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERROR = 3;

    logic             Clk;
    logic             Rst;
    logic             InstrValid;
    logic [31:0]      Instruction;
    logic             InstrReady;
    logic             LoadEn;
    logic [1:0]       LoadRow;
    logic [1:0]       LoadCol;
    logic             SADsignal;
    logic             SadStart;
    logic [1:0]       CandRow;
    logic [1:0]       CandCol;
    logic             SadValid;
    logic [SAD_W-1:0] SadValue;
    logic             Done;
    logic [SAD_W-1:0] BestSad;
    logic [1:0]       BestRow;
    logic [1:0]       BestCol;
    logic             Error;

    sad_thread_controller #(
        .OPC_SAD (OPC_SAD),
        .OPC_LOAD(OPC_LOAD),
        .BLK     (BLK),
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H),
        .SAD_W   (SAD_W)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .InstrValid (InstrValid),
        .Instruction(Instruction),
        .InstrReady (InstrReady),
        .LoadEn     (LoadEn),
        .LoadRow    (LoadRow),
        .LoadCol    (LoadCol),
        .SADsignal  (SADsignal),
        .SadStart   (SadStart),
        .CandRow    (CandRow),
        .CandCol    (CandCol),
        .SadValid   (SadValid),
        .SadValue   (SadValue),
        .Done       (Done),
        .BestSad    (BestSad),
        .BestRow    (BestRow),
        .BestCol    (BestCol),
        .Error      (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec   = 0;
    int  n_fail  = 0;
    int  n_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind, input int a, input int b, input int c);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input int a, input int b, input int c);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (kind == e.kind) begin
                check("event_field_a", 32'(a), 32'(e.a));
                check("event_field_b", 32'(b), 32'(e.b));
                check("event_field_c", 32'(c), 32'(e.c));
            end
        end
    endtask

    // Monitor: every output event the DUT presents is matched to the queue.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                if (LoadEn)   got(K_LOAD, 32'(LoadRow), 32'(LoadCol), 0);
                if (SadStart) begin
                    got(K_START, 32'(CandRow), 32'(CandCol), 0);
                    n_start++;
                end
                if (Done)     got(K_DONE, 32'(BestSad), 32'(BestRow), 32'(BestCol));
                if (Error)    got(K_ERROR, 0, 0, 0);
            end
        end
    end

    // SAD unit model: answers each SadStart after a (possibly random) delay.
    int sad_vals [9] = '{9, 8, 7, 5, 6, 5, 9, 9, 9};
    int model_idx     = 0;
    bit model_en      = 1'b0;
    bit pending       = 1'b0;
    int cnt           = 0;
    int max_delay     = 0;
    bit spur_mode     = 1'b0;
    bit spur_next     = 1'b0;
    int glitch_cycles = 0;

    initial begin
        forever begin
            @(negedge Clk);
            if (model_en && SadStart && !Rst) begin
                pending = 1'b1;
                cnt     = (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
            end
        end
    end

    initial begin
        SadValid = 1'b0;
        SadValue = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (glitch_cycles > 0) begin
                SadValid = 1'b1;
                SadValue = SAD_W'(1);
                glitch_cycles--;
            end else if (!model_en) begin
                SadValid  = 1'b0;
                pending   = 1'b0;
                spur_next = 1'b0;
            end else if (pending && cnt == 0) begin
                SadValid  = 1'b1;
                SadValue  = SAD_W'(sad_vals[model_idx % 9]);
                model_idx++;
                pending   = 1'b0;
                spur_next = spur_mode;
            end else if (spur_next) begin
                // Extra strobe lands in the following LAUNCH (or FINISH) cycle.
                SadValid  = 1'b1;
                SadValue  = '0;
                spur_next = 1'b0;
            end else begin
                SadValid = 1'b0;
                if (pending) cnt--;
            end
        end
    end

    task automatic issue(input logic [5:0] opc);
        @(posedge Clk);
        #1;
        InstrValid  = 1'b1;
        Instruction = {opc, 26'h0};
        @(posedge Clk);
        #1;
        InstrValid  = 1'b0;
        Instruction = '0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge Clk);
            cycles++;
        end while (!Done && cycles < 400);
        if (!Done) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic push_sweep(input int n_cand, input bit with_done);
        for (int i = 0; i < n_cand; i++) push(K_START, i / WIN_W, i % WIN_W, 0);
        if (with_done) push(K_DONE, 5, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 0, required 1");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int cycles;
        int base;
        int tries;

        Rst         = 1'b1;
        InstrValid  = 1'b0;
        Instruction = '0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;

        // Reset state.
        @(negedge Clk);
        check("rst_instr_ready", 32'(InstrReady), 32'(1));
        check("rst_load_en",     32'(LoadEn),     32'(0));
        check("rst_sad_start",   32'(SadStart),   32'(0));
        check("rst_sad_signal",  32'(SADsignal),  32'(0));
        check("rst_done",        32'(Done),       32'(0));
        check("rst_error",       32'(Error),      32'(0));
        check("rst_best_sad",    32'(BestSad),    32'hFFFF);
        check("rst_best_pos",    32'({BestRow, BestCol}), 32'(0));

        // Sweep without a template: Error one cycle after acceptance.
        push(K_ERROR, 0, 0, 0);
        issue(OPC_SAD);
        @(negedge Clk);
        check("noload_error",     32'(Error),      32'(1));
        check("noload_ready",     32'(InstrReady), 32'(1));
        check("noload_sad_start", 32'(SadStart),   32'(0));
        @(negedge Clk);
        check("noload_error_off", 32'(Error),      32'(0));

        // Template load: 16 LoadEn cycles, column fastest.
        for (int r = 0; r < BLK; r++)
            for (int c = 0; c < BLK; c++) push(K_LOAD, r, c, 0);
        issue(OPC_LOAD);
        for (int i = 0; i < BLK * BLK; i++) begin
            @(negedge Clk);
            check("load_ready_low", 32'(InstrReady), 32'(0));
        end
        @(negedge Clk);
        check("load_ready_back", 32'(InstrReady), 32'(1));
        check("load_en_off",     32'(LoadEn),     32'(0));

        // Sweep with immediate answers: 2 cycles per candidate, Done at 19.
        model_idx = 0;
        max_delay = 0;
        spur_mode = 1'b0;
        model_en  = 1'b1;
        push_sweep(WIN_W * WIN_H, 1'b1);
        issue(OPC_SAD);
        wait_done(cycles);
        check("sweep0_done_cycle", 32'(cycles), 32'(19));
        @(negedge Clk);
        check("sweep0_done_pulse", 32'(Done),       32'(0));
        check("sweep0_ready",      32'(InstrReady), 32'(1));
        check("sweep0_best_hold",  32'(BestSad),    32'(5));

        // Same sweep, random latency plus spurious strobes in IDLE and LAUNCH.
        glitch_cycles = 3;
        repeat (4) @(negedge Clk);
        model_idx = 0;
        max_delay = 5;
        spur_mode = 1'b1;
        push_sweep(WIN_W * WIN_H, 1'b1);
        issue(OPC_SAD);
        wait_done(cycles);
        repeat (3) @(negedge Clk);
        check("sweep1_best_sad", 32'(BestSad), 32'(5));
        check("sweep1_best_pos", 32'({BestRow, BestCol}), 32'({2'd1, 2'd0}));

        // Reset during WAIT of the 4th candidate.
        model_idx = 0;
        max_delay = 0;
        spur_mode = 1'b0;
        base      = n_start;
        push_sweep(4, 1'b0);
        issue(OPC_SAD);
        tries = 0;
        while (n_start < base + 4 && tries < 100) begin
            @(negedge Clk);
            tries++;
        end
        check("rst_test_reached_4th", 32'(n_start - base), 32'(4));
        @(posedge Clk);
        #1;
        Rst      = 1'b1;
        model_en = 1'b0;
        #1;
        check("midrst_sad_signal", 32'(SADsignal),  32'(0));
        check("midrst_done",       32'(Done),       32'(0));
        check("midrst_best_sad",   32'(BestSad),    32'hFFFF);
        check("midrst_ready",      32'(InstrReady), 32'(1));
        @(posedge Clk);
        #1 Rst = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            check("midrst_no_done", 32'(Done), 32'(0));
        end
        push(K_ERROR, 0, 0, 0);
        issue(OPC_SAD);
        @(negedge Clk);
        check("midrst_loaded_cleared", 32'(Error), 32'(1));

        // Unknown opcode: accepted and ignored.
        issue(6'b000000);
        repeat (4) begin
            @(negedge Clk);
            check("nop_ready", 32'(InstrReady), 32'(1));
        end

        repeat (3) @(negedge Clk);
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
